// File: rtl/uart_alu_frame_if.sv
// rtl/uart_alu_frame_if.sv - UART/ALU side signal bundle for the frame controller
interface uart_alu_frame_if #(
    parameter int NB_DATA = 32,
    parameter int NB_OP   = 6
) ();
    logic [7:0]         i_rx;
    logic               i_rxDone;
    logic               i_txDone;
    logic               o_tx_start;
    logic [7:0]         o_data;
    logic [NB_DATA-1:0] o_datoA;
    logic [NB_DATA-1:0] o_datoB;
    logic [NB_OP-1:0]   o_operation;
    logic               o_valid;
    logic [NB_DATA-1:0] i_result;
    logic               o_err_tag;
    logic               o_err_timeout;
    logic               o_busy;

    modport slave (
        input  i_rx, i_rxDone, i_txDone, i_result,
        output o_tx_start, o_data, o_datoA, o_datoB, o_operation, o_valid,
               o_err_tag, o_err_timeout, o_busy
    );

    modport master (
        output i_rx, i_rxDone, i_txDone, i_result,
        input  o_tx_start, o_data, o_datoA, o_datoB, o_operation, o_valid,
               o_err_tag, o_err_timeout, o_busy
    );
endinterface

// File: rtl/uart_alu_frame_ctrl.sv
// rtl/uart_alu_frame_ctrl.sv - tagged UART frame parser driving an ALU and streaming the result back
module uart_alu_frame_ctrl #(
    parameter int          NB_DATA = 32,
    parameter int          NB_OP   = 6,
    parameter int          TIMEOUT = 100000,
    parameter logic [7:0]  TAG_A   = 8'h08,
    parameter logic [7:0]  TAG_B   = 8'h10,
    parameter logic [7:0]  TAG_OP  = 8'h20
) (
    input  logic             clk,
    input  logic             i_rst,
    uart_alu_frame_if.slave  bus
);
    localparam int NBYTES = NB_DATA / 8;
    localparam int CW     = $clog2(NBYTES) + 1;
    localparam int TW     = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {IDLE, PAYLOAD, EXEC, TX_SEND, TX_WAIT} state_t;
    typedef enum logic [1:0] {K_A, K_B, K_OP} kind_t;

    state_t             state_q, state_d;
    kind_t              kind_q, kind_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CW-1:0]      tx_cnt_q, tx_cnt_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [NB_DATA-1:0] asm_q, asm_d, asm_next;
    logic [NB_DATA-1:0] shift_q, shift_d;
    logic [NB_DATA-1:0] dato_a_q, dato_a_d;
    logic [NB_DATA-1:0] dato_b_q, dato_b_d;
    logic [NB_OP-1:0]   op_q, op_d;
    logic [7:0]         data_q, data_d;
    logic               valid_q, valid_d;
    logic               tx_start_q, tx_start_d;
    logic               err_tag_q, err_tag_d;
    logic               err_to_q, err_to_d;
    logic               busy_q, busy_d;

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        cnt_d      = cnt_q;
        tx_cnt_d   = tx_cnt_q;
        timer_d    = timer_q;
        asm_d      = asm_q;
        shift_d    = shift_q;
        dato_a_d   = dato_a_q;
        dato_b_d   = dato_b_q;
        op_d       = op_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        tx_start_d = 1'b0;
        err_tag_d  = 1'b0;
        err_to_d   = 1'b0;
        asm_next   = asm_q;
        asm_next[8*int'(cnt_q) +: 8] = bus.i_rx;

        case (state_q)
            IDLE: begin
                if (bus.i_rxDone) begin
                    if (bus.i_rx == TAG_A || bus.i_rx == TAG_B || bus.i_rx == TAG_OP) begin
                        kind_d  = (bus.i_rx == TAG_A) ? K_A : ((bus.i_rx == TAG_B) ? K_B : K_OP);
                        cnt_d   = '0;
                        timer_d = '0;
                        asm_d   = '0;
                        state_d = PAYLOAD;
                    end else begin
                        err_tag_d = 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                if (bus.i_rxDone) begin
                    timer_d = '0;
                    cnt_d   = cnt_q + CW'(1);
                    asm_d   = asm_next;
                    if (kind_q == K_OP) begin
                        op_d    = bus.i_rx[NB_OP-1:0];
                        valid_d = 1'b1;
                        state_d = EXEC;
                    end else if (cnt_q == CW'(NBYTES - 1)) begin
                        // Whole word lands in one update so the ALU never sees a partial operand
                        if (kind_q == K_A) begin
                            dato_a_d = asm_next;
                        end else begin
                            dato_b_d = asm_next;
                        end
                        asm_d   = '0;
                        state_d = IDLE;
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    err_to_d = 1'b1;
                    asm_d    = '0;
                    state_d  = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            EXEC: begin
                shift_d    = bus.i_result;
                data_d     = bus.i_result[7:0];
                tx_cnt_d   = '0;
                tx_start_d = 1'b1;
                state_d    = TX_SEND;
            end
            TX_SEND: begin
                state_d = TX_WAIT;
            end
            TX_WAIT: begin
                if (bus.i_txDone) begin
                    if (tx_cnt_q == CW'(NBYTES - 1)) begin
                        state_d = IDLE;
                    end else begin
                        shift_d    = shift_q >> 8;
                        data_d     = shift_d[7:0];
                        tx_cnt_d   = tx_cnt_q + CW'(1);
                        tx_start_d = 1'b1;
                        state_d    = TX_SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            kind_q     <= K_A;
            cnt_q      <= '0;
            tx_cnt_q   <= '0;
            timer_q    <= '0;
            asm_q      <= '0;
            shift_q    <= '0;
            dato_a_q   <= '0;
            dato_b_q   <= '0;
            op_q       <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            tx_start_q <= 1'b0;
            err_tag_q  <= 1'b0;
            err_to_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            cnt_q      <= cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            timer_q    <= timer_d;
            asm_q      <= asm_d;
            shift_q    <= shift_d;
            dato_a_q   <= dato_a_d;
            dato_b_q   <= dato_b_d;
            op_q       <= op_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            tx_start_q <= tx_start_d;
            err_tag_q  <= err_tag_d;
            err_to_q   <= err_to_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.o_tx_start    = tx_start_q;
    assign bus.o_data        = data_q;
    assign bus.o_datoA       = dato_a_q;
    assign bus.o_datoB       = dato_b_q;
    assign bus.o_operation   = op_q;
    assign bus.o_valid       = valid_q;
    assign bus.o_err_tag     = err_tag_q;
    assign bus.o_err_timeout = err_to_q;
    assign bus.o_busy        = busy_q;
endmodule

// File: tb/tb_uart_alu_frame_ctrl.sv
// tb/tb_uart_alu_frame_ctrl.sv - scoreboard bench for uart_alu_frame_ctrl (16-bit operands, timeout 20)
module tb_uart_alu_frame_ctrl;
    localparam int NB = 16;
    localparam int TO = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_alu_frame_if #(.NB_DATA(NB), .NB_OP(6)) bus ();

    uart_alu_frame_ctrl #(.NB_DATA(NB), .NB_OP(6), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [5:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        int          vcyc;
    } opexp_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    opexp_t      op_q[$];
    logic [7:0]  tx_q[$];
    logic [15:0] a_q[$];
    logic [15:0] b_q[$];
    int          tag_q[$];
    int          to_q[$];
    logic [15:0] m_a = '0;
    logic [15:0] m_b = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc > 50000) begin
            $display("FAIL watchdog: got cycle %0d expected below 50000", cyc);
            $fatal(1, "watchdog expired");
        end
    end

    // Monitor: every DUT event is matched against the oldest expectation of its kind
    logic        prev_valid = 1'b0;
    logic        first_pend = 1'b0;
    int          vcyc_l     = 0;
    logic [15:0] last_a     = '0;
    logic [15:0] last_b     = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_valid) begin
                chk("valid_single_cycle", 32'(prev_valid), 32'd0);
                chk("valid_expected", 32'(op_q.size() != 0), 32'd1);
                if (op_q.size() != 0) begin
                    chk("valid_opcode", 32'(bus.o_operation), 32'(op_q[0].op));
                    chk("valid_datoA", 32'(bus.o_datoA), 32'(op_q[0].a));
                    chk("valid_datoB", 32'(bus.o_datoB), 32'(op_q[0].b));
                    chk("valid_latency", cyc, op_q[0].vcyc);
                    void'(op_q.pop_front());
                end
                first_pend <= 1'b1;
                vcyc_l     <= cyc;
            end
            prev_valid <= bus.o_valid;
            if (bus.o_tx_start) begin
                chk("tx_expected", 32'(tx_q.size() != 0), 32'd1);
                if (tx_q.size() != 0) begin
                    chk("tx_byte", 32'(bus.o_data), 32'(tx_q[0]));
                    void'(tx_q.pop_front());
                end
                if (first_pend) chk("tx_first_latency", cyc, vcyc_l + 1);
                first_pend <= 1'b0;
            end
            if (bus.o_err_tag) begin
                chk("err_tag_expected", 32'(tag_q.size() != 0), 32'd1);
                if (tag_q.size() != 0) begin
                    chk("err_tag_cycle", cyc, tag_q[0]);
                    void'(tag_q.pop_front());
                end
            end
            if (bus.o_err_timeout) begin
                chk("err_timeout_expected", 32'(to_q.size() != 0), 32'd1);
                if (to_q.size() != 0) begin
                    chk("err_timeout_cycle", cyc, to_q[0]);
                    void'(to_q.pop_front());
                end
            end
            if (bus.o_datoA != last_a) begin
                chk("datoA_change_expected", 32'(a_q.size() != 0), 32'd1);
                if (a_q.size() != 0) begin
                    chk("datoA_value", 32'(bus.o_datoA), 32'(a_q[0]));
                    void'(a_q.pop_front());
                end
                last_a <= bus.o_datoA;
            end
            if (bus.o_datoB != last_b) begin
                chk("datoB_change_expected", 32'(b_q.size() != 0), 32'd1);
                if (b_q.size() != 0) begin
                    chk("datoB_value", 32'(bus.o_datoB), 32'(b_q[0]));
                    void'(b_q.pop_front());
                end
                last_b <= bus.o_datoB;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        bus.i_rx     = b;
        bus.i_rxDone = 1'b1;
        @(negedge clk);
        bus.i_rxDone = 1'b0;
        bus.i_rx     = 8'($urandom);
    endtask

    task automatic gap(input int fixed);
        if (fixed < 0) repeat ($urandom_range(0, 3)) @(negedge clk);
        else repeat (fixed) @(negedge clk);
    endtask

    task automatic frame_ab(input bit is_b, input logic [15:0] v, input int fixed_gap);
        send(is_b ? 8'h10 : 8'h08);
        gap(fixed_gap);
        send(v[7:0]);
        gap(fixed_gap);
        if (is_b) begin
            if (v != m_b) b_q.push_back(v);
            m_b = v;
        end else begin
            if (v != m_a) a_q.push_back(v);
            m_a = v;
        end
        send(v[15:8]);
        chk(is_b ? "datoB_one_cycle_after" : "datoA_one_cycle_after",
            32'(is_b ? bus.o_datoB : bus.o_datoA), 32'(v));
    endtask

    task automatic frame_op(input logic [7:0] opc, input logic [15:0] res);
        opexp_t e;
        int sent;
        int guard;
        bus.i_result = res;
        send(8'h20);
        gap(-1);
        e.op   = opc[5:0];
        e.a    = m_a;
        e.b    = m_b;
        e.vcyc = cyc + 1;
        op_q.push_back(e);
        tx_q.push_back(res[7:0]);
        tx_q.push_back(res[15:8]);
        send(opc);
        sent  = 0;
        guard = 0;
        while (sent < 2 && guard < 100) begin
            guard++;
            if (bus.o_tx_start) begin
                repeat ($urandom_range(1, 4)) begin
                    if ($urandom_range(0, 1) == 1) begin
                        bus.i_rx     = 8'($urandom);
                        bus.i_rxDone = 1'b1;
                    end
                    @(negedge clk);
                    bus.i_rxDone = 1'b0;
                end
                bus.i_txDone = 1'b1;
                if ($urandom_range(0, 1) == 1) begin
                    bus.i_rx     = 8'($urandom);
                    bus.i_rxDone = 1'b1;
                end
                @(negedge clk);
                bus.i_txDone = 1'b0;
                bus.i_rxDone = 1'b0;
                sent++;
            end else begin
                @(negedge clk);
            end
        end
        chk("reply_bytes_sent", sent, 2);
        @(negedge clk);
        chk("busy_after_reply", 32'(bus.o_busy), 32'd0);
    endtask

    task automatic bad_tag(input logic [7:0] v);
        tag_q.push_back(cyc + 1);
        send(v);
        chk("busy_after_bad_tag", 32'(bus.o_busy), 32'd0);
        chk("datoA_after_bad_tag", 32'(bus.o_datoA), 32'(m_a));
    endtask

    task automatic timeout_frame(input bit is_b, input int nbytes);
        int k;
        k = cyc;
        send(is_b ? 8'h10 : 8'h08);
        for (int i = 0; i < nbytes; i++) begin
            gap(-1);
            k = cyc;
            send(8'hAA);
        end
        to_q.push_back(k + 1 + TO);
        repeat (TO + 2) @(negedge clk);
        chk("datoA_after_timeout", 32'(bus.o_datoA), 32'(m_a));
        chk("datoB_after_timeout", 32'(bus.o_datoB), 32'(m_b));
        chk("busy_after_timeout", 32'(bus.o_busy), 32'd0);
    endtask

    task automatic reset_mid_tx();
        opexp_t e;
        int guard;
        bus.i_result = 16'hC0DE;
        send(8'h20);
        e.op   = 6'h15;
        e.a    = m_a;
        e.b    = m_b;
        e.vcyc = cyc + 1;
        op_q.push_back(e);
        tx_q.push_back(8'hDE);
        send(8'h15);
        guard = 0;
        while (!bus.o_tx_start && guard < 20) begin
            guard++;
            @(negedge clk);
        end
        chk("tx_before_reset", 32'(bus.o_tx_start), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        if (m_a != 16'h0) a_q.push_back(16'h0);
        if (m_b != 16'h0) b_q.push_back(16'h0);
        m_a = '0;
        m_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_tx_datoA", 32'(bus.o_datoA), 32'd0);
        chk("rst_tx_datoB", 32'(bus.o_datoB), 32'd0);
        chk("rst_tx_data", 32'(bus.o_data), 32'd0);
        chk("rst_tx_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_tx_start", 32'(bus.o_tx_start), 32'd0);
        bus.i_txDone = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        bus.i_txDone = 1'b0;
        repeat (6) @(negedge clk);
        chk("no_tx_after_reset", tx_q.size(), 0);
        chk("idle_after_reset", 32'(bus.o_busy), 32'd0);
    endtask

    initial begin
        logic [7:0] v;
        bus.i_rx     = '0;
        bus.i_rxDone = 1'b0;
        bus.i_txDone = 1'b0;
        bus.i_result = '0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_tx_start", 32'(bus.o_tx_start), 32'd0);
        chk("reset_data", 32'(bus.o_data), 32'd0);
        chk("reset_datoA", 32'(bus.o_datoA), 32'd0);
        chk("reset_datoB", 32'(bus.o_datoB), 32'd0);
        chk("reset_operation", 32'(bus.o_operation), 32'd0);
        chk("reset_valid", 32'(bus.o_valid), 32'd0);
        chk("reset_err_tag", 32'(bus.o_err_tag), 32'd0);
        chk("reset_err_timeout", 32'(bus.o_err_timeout), 32'd0);
        chk("reset_busy", 32'(bus.o_busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        frame_ab(1'b0, 16'h1234, -1);
        frame_ab(1'b1, 16'h0005, -1);
        frame_op(8'h20, 16'hBEEF);
        bad_tag(8'h7F);
        frame_ab(1'b0, 16'hBBAA, TO - 1);
        timeout_frame(1'b0, 1);
        frame_ab(1'b0, 16'h5678, -1);
        reset_mid_tx();

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0: frame_ab(1'b0, 16'($urandom), -1);
                1: frame_ab(1'b1, 16'($urandom), -1);
                2, 3: frame_op(8'($urandom), 16'($urandom));
                4: begin
                    do v = 8'($urandom);
                    while (v == 8'h08 || v == 8'h10 || v == 8'h20);
                    bad_tag(v);
                end
                default: timeout_frame($urandom_range(0, 1) == 1, $urandom_range(0, 1));
            endcase
            gap(-1);
        end

        repeat (5) @(negedge clk);
        chk("op_queue_drained", op_q.size(), 0);
        chk("tx_queue_drained", tx_q.size(), 0);
        chk("datoA_queue_drained", a_q.size(), 0);
        chk("datoB_queue_drained", b_q.size(), 0);
        chk("err_tag_queue_drained", tag_q.size(), 0);
        chk("err_timeout_queue_drained", to_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
